// File: rtl/memwb_pkg.sv
// Shared types and constants for the MEM/WB pipeline stage.
package memwb_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_REG_ADDR_W = 5;
  localparam int ZERO_REG       = 0;

  // Field order matches the flat payload vector packed by memwb_stage (MSB first).
  typedef struct packed {
    logic [DEF_DATA_W-1:0]     read_data;
    logic [DEF_DATA_W-1:0]     alu_data;
    logic [DEF_REG_ADDR_W-1:0] wr_reg;
    logic                      reg_wr;
    logic                      mem_to_reg;
    logic [DEF_DATA_W-1:0]     wb_data;
  } memwb_payload_t;

endpackage

// File: rtl/memwb_stage_skid_slot.sv
// Payload register with a valid bit; clear has priority over load.
module skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/memwb_stage.sv
// MEM/WB stage: main + skid slot with valid/ready, flush and registered writeback select.
// Optional performance counters are enabled with `define MEMWB_STAGE_PERF_EN.
module memwb_stage
  import memwb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
`ifdef MEMWB_STAGE_PERF_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_read_data,
  input  logic [DATA_W-1:0]     in_alu_data,
  input  logic [REG_ADDR_W-1:0] in_wr_reg,
  input  logic                  in_reg_wr,
  input  logic                  in_mem_to_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_read_data,
  output logic [DATA_W-1:0]     out_alu_data,
  output logic [REG_ADDR_W-1:0] out_wr_reg,
  output logic                  out_reg_wr,
  output logic                  out_mem_to_reg,
  output logic [DATA_W-1:0]     out_wb_data
`ifdef MEMWB_STAGE_PERF_EN
  , output logic [CNT_W-1:0]    stall_cnt
  , output logic [CNT_W-1:0]    bubble_cnt
`endif
);

  localparam int PW = 3 * DATA_W + REG_ADDR_W + 2;

  logic          main_valid, skid_valid;
  logic [PW-1:0] main_q, skid_q, in_pl, main_d;
  logic          main_load, main_clr, skid_load, skid_clr;
  logic          accept, consume, main_free;
  logic          held_reg_wr;

  // Writeback select is resolved on entry so the output is a plain register.
  assign in_pl = {in_read_data, in_alu_data, in_wr_reg, in_reg_wr, in_mem_to_reg,
                  (in_mem_to_reg ? in_read_data : in_alu_data)};

  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & ~skid_valid;
  assign consume   = main_valid & out_ready;
  assign main_free = ~main_valid | consume;
  assign main_d    = skid_valid ? skid_q : in_pl;

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (main_free) begin
      if (skid_valid) begin
        main_load = 1'b1;
        if (accept) begin
          skid_load = 1'b1;
        end else begin
          skid_clr = 1'b1;
        end
      end else if (accept) begin
        main_load = 1'b1;
      end else begin
        main_clr = 1'b1;
      end
    end else if (accept) begin
      skid_load = 1'b1;
    end else begin
      skid_load = 1'b0;
    end
  end

  skid_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .valid (main_valid),
    .q     (main_q)
  );

  skid_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_pl),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign {out_read_data, out_alu_data, out_wr_reg, held_reg_wr, out_mem_to_reg,
          out_wb_data} = main_q;
  assign out_valid  = main_valid;
  assign out_reg_wr = main_valid & held_reg_wr &
                      (out_wr_reg != REG_ADDR_W'(ZERO_REG));

`ifdef MEMWB_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q;
  logic             bubble_evt;

  // A flush counts once as a bubble only when it actually drops an entry.
  assign bubble_evt = flush ? (main_valid | skid_valid | accept) : ~main_valid;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (bubble_evt && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
